// File: rtl/immgen_pipe.sv
// Multi-lane RV32I/F immediate decoder feeding a 2-entry output FIFO.
// Valid/ready on both sides: a transfer happens on a rising edge where valid && ready.
module immgen_pipe #(
    parameter int XLEN     = 32,
    parameter int LANES    = 1,
    parameter bit FLOAT_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [32*LANES-1:0]     in_instr,
    input  logic [LANES-1:0]        in_lane_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN*LANES-1:0]   out_imm,
    output logic [3*LANES-1:0]      out_fmt,
    output logic [LANES-1:0]        out_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_FLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FSTORE = 7'b0100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } dec_t;

    function automatic dec_t decode_lane(input logic [31:0] instr, input logic en);
        dec_t       d;
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
        imm32 = '0;
        fmt   = FMT_NONE;
        ill   = 1'b0;
        case (instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_FLOAD: begin
                if (FLOAT_EN) begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_FSTORE: begin
                if (FLOAT_EN) begin
                    fmt   = FMT_S;
                    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_OP, OPC_OP_FP: begin
                fmt = FMT_NONE;
            end
            default: ill = 1'b1;
        endcase
        // Upper bits replicate instr[31] for every format; NONE stays all-zero.
        d.imm       = {XLEN{instr[31]}};
        d.imm[31:0] = imm32;
        if (fmt == FMT_NONE) d.imm = '0;
        d.fmt = fmt;
        d.ill = ill;
        if (!en) d = '0;
        return d;
    endfunction

    logic [XLEN*LANES-1:0] dec_imm;
    logic [3*LANES-1:0]    dec_fmt;
    logic [LANES-1:0]      dec_ill;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dec_t d;
        assign d = decode_lane(in_instr[32*k +: 32], in_lane_en[k]);
        assign dec_imm[XLEN*k +: XLEN] = d.imm;
        assign dec_fmt[3*k +: 3]       = d.fmt;
        assign dec_ill[k]              = d.ill;
    end

    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [XLEN*LANES-1:0] mem_imm [2];
    logic [3*LANES-1:0]    mem_fmt [2];
    logic [LANES-1:0]      mem_ill [2];
    logic                  push;
    logic                  pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_imm[i] <= '0;
                mem_fmt[i] <= '0;
                mem_ill[i] <= '0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_imm[wr_ptr] <= dec_imm;
                mem_fmt[wr_ptr] <= dec_fmt;
                mem_ill[wr_ptr] <= dec_ill;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Outputs come only from the head entry and read as zero when empty.
    assign out_imm     = out_valid ? mem_imm[rd_ptr] : '0;
    assign out_fmt     = out_valid ? mem_fmt[rd_ptr] : '0;
    assign out_illegal = out_valid ? mem_ill[rd_ptr] : '0;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: a 32-bit single-lane instance and a 64-bit two-lane instance.
module tb_immgen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // XLEN=32, LANES=1 instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_instr, a_out_imm;
    logic [0:0]  a_lane_en, a_out_ill;
    logic [2:0]  a_out_fmt;

    // XLEN=64, LANES=2 instance
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0]  b_in_instr;
    logic [1:0]   b_lane_en, b_out_ill;
    logic [127:0] b_out_imm;
    logic [5:0]   b_out_fmt;

    immgen_pipe #(.XLEN(32), .LANES(1), .FLOAT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_lane_en(a_lane_en),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_ill)
    );

    immgen_pipe #(.XLEN(64), .LANES(2), .FLOAT_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_lane_en(b_lane_en),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_ill)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input string tag, input logic [31:0] instr,
                          input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_ill);
        a_in_instr = instr;
        a_in_valid = 1'b1;
        check({tag, "_rdy"}, a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        a_in_instr = '0;
        check({tag, "_vld"}, a_out_valid, 1);
        check({tag, "_imm"}, a_out_imm, e_imm);
        check({tag, "_fmt"}, a_out_fmt, e_fmt);
        check({tag, "_ill"}, a_out_ill, e_ill);
        tick();
        check({tag, "_empty"}, {a_out_valid, a_out_imm, a_out_fmt, a_out_ill}, 0);
    endtask

    task automatic push_b(input string tag, input logic [63:0] instr, input logic [1:0] en,
                          input logic [127:0] e_imm, input logic [5:0] e_fmt, input logic [1:0] e_ill);
        b_in_instr = instr;
        b_lane_en  = en;
        b_in_valid = 1'b1;
        check({tag, "_rdy"}, b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        b_in_instr = '0;
        check({tag, "_vld"}, b_out_valid, 1);
        check({tag, "_imm"}, b_out_imm, e_imm);
        check({tag, "_fmt"}, b_out_fmt, e_fmt);
        check({tag, "_ill"}, b_out_ill, e_ill);
        tick();
        check({tag, "_empty"}, {b_out_valid, b_out_imm, b_out_fmt, b_out_ill}, 0);
    endtask

    initial begin
        a_flush = 0; a_in_valid = 0; a_in_instr = '0; a_lane_en = 1'b1; a_out_ready = 1;
        b_flush = 0; b_in_valid = 0; b_in_instr = '0; b_lane_en = 2'b11; b_out_ready = 1;

        // clock/reset
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_a", {a_out_valid, a_in_ready, a_out_imm}, {1'b0, 1'b1, 32'h0});
        check("rst_b", {b_out_valid, b_in_ready, b_out_imm}, {1'b0, 1'b1, 128'h0});
        rst = 1'b0;
        tick();

        // XLEN=32 single lane: one vector per format
        push_a("lui",   32'h123450B7, 32'h12345000, 3'd4, 1'b0);
        push_a("beq",   32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
        push_a("sw",    32'hFE512C23, 32'hFFFFFFF8, 3'd2, 1'b0);
        push_a("jalm4", 32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0);
        push_a("auipc", 32'h00001017, 32'h00001000, 3'd4, 1'b0);
        push_a("flw",   32'h80002007, 32'hFFFFF800, 3'd1, 1'b0);
        push_a("fsw",   32'h00000027, 32'h00000000, 3'd2, 1'b0);
        push_a("op",    32'hFFF00033, 32'h00000000, 3'd0, 1'b0);
        push_a("bad",   32'h0000007F, 32'h00000000, 3'd0, 1'b1);

        // XLEN=64 two lanes
        push_b("x64", {32'hFFF00093, 32'h800002B7}, 2'b11,
               {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000}, {3'd1, 3'd4}, 2'b00);
        push_b("jal_bad", {32'hFFFFFFFF, 32'h0000006F}, 2'b11, 128'h0, {3'd0, 3'd5}, 2'b10);
        push_b("lane_off", {32'hFFFFFFFF, 32'h0000006F}, 2'b01, 128'h0, {3'd0, 3'd5}, 2'b00);
        push_b("lane_off2", {32'hFFF00093, 32'h00000013}, 2'b01, 128'h0, {3'd0, 3'd1}, 2'b00);

        // Backpressure: A and B fill the buffer, C waits
        b_out_ready = 1'b0;
        b_lane_en   = 2'b11;
        b_in_valid  = 1'b1;
        b_in_instr  = {32'h00000033, 32'h00100093};
        check("bp_rdy_a", b_in_ready, 1);
        tick();
        exp_q.push_back(128'h1);
        check("bp_vld", b_out_valid, 1);
        check("bp_head_a", b_out_imm, exp_q[0]);
        b_in_instr = {32'h00000033, 32'h00200093};
        check("bp_rdy_b", b_in_ready, 1);
        tick();
        exp_q.push_back(128'h2);
        b_in_instr = {32'h00000033, 32'h00300093};
        check("bp_full", b_in_ready, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_stall_imm", b_out_imm, exp_q[0]);
            check("bp_stall_rdy", b_in_ready, 0);
        end
        b_out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        check("bp_head_b", b_out_imm, exp_q[0]);
        check("bp_rdy_c", b_in_ready, 1);
        tick();
        exp_q.push_back(128'h3);
        void'(exp_q.pop_front());
        b_in_valid = 1'b0;
        check("bp_head_c", b_out_imm, exp_q[0]);
        check("bp_fmt_c", b_out_fmt, {3'd0, 3'd1});
        tick();
        void'(exp_q.pop_front());
        check("bp_done", b_out_valid, 0);
        tick();
        check("bp_no_dup", b_out_valid, 0);

        // Flush with two entries held, bundle offered alongside
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_instr  = {32'h00000033, 32'h00400093};
        tick();
        b_in_instr  = {32'h00000033, 32'h00500093};
        tick();
        check("fl_full", b_in_ready, 0);
        b_in_instr  = {32'h00000033, 32'h00600093};
        b_flush     = 1'b1;
        tick();
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        check("fl2_vld", b_out_valid, 0);
        check("fl2_rdy", b_in_ready, 1);
        check("fl2_imm", b_out_imm, 0);
        // Flush with one entry held: the concurrent push must be dropped
        b_in_valid  = 1'b1;
        b_in_instr  = {32'h00000033, 32'h00400093};
        tick();
        b_in_instr  = {32'h00000033, 32'h00600093};
        b_flush     = 1'b1;
        tick();
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        check("fl1_vld", b_out_valid, 0);
        tick();
        check("fl1_no_push", b_out_valid, 0);
        b_out_ready = 1'b1;
        push_b("fl_after", {32'h00000033, 32'h00700093}, 2'b11, 128'h7, {3'd0, 3'd1}, 2'b00);

        // Asynchronous reset between edges drops both entries
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_instr  = {32'h00000033, 32'h00400093};
        tick();
        b_in_instr  = {32'h00000033, 32'h00500093};
        tick();
        b_in_valid  = 1'b0;
        check("ar_pre_vld", b_out_valid, 1);
        #3 rst = 1'b1;
        #1;
        check("ar_vld", b_out_valid, 0);
        check("ar_rdy", b_in_ready, 1);
        check("ar_imm", b_out_imm, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        b_out_ready = 1'b1;
        push_b("ar_first", {32'h00000033, 32'h00700093}, 2'b11, 128'h7, {3'd0, 3'd1}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
